// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl -- byte-wide SPI master transfer sequencer.
//
// Shifts one byte out on mosi and one byte in from miso. Each sample strobe
// from the external baud-rate generator advances the transfer by one bit.
// The strobe is flag_low when cpol == cpha, otherwise it is flag_high.
// The block runs only while enabled: spi_mode == run, or spi_mode == wait
// with spiswai clear. If it loses enable mid-byte, the transfer aborts
// without updating data_miso.
//
// Ports
//   PCLK          in   system clock
//   PRESETn       in   asynchronous active-low reset
//   spi_mode[1:0] in   00 run, 01 wait, 1x stop
//   spiswai       in   stop-in-wait
//   send_data     in   transfer request (level, sampled in IDLE)
//   data_mosi[7:0]in   byte to transmit
//   lsbfe         in   1 = LSB first
//   cpol, cpha    in   select which strobe samples
//   flag_low/high in   sample strobes
//   miso          in   serial input
//   ss            out  slave select, active-low
//   mosi          out  serial output
//   tip           out  transfer in progress
//   receive_data  out  one-cycle pulse coincident with the data_miso update
//   data_miso[7:0]out  last completed received byte
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ss high, waiting for send_data while enabled
// XFER  | ss low, one bit per sample strobe, aborts if enable drops
// DONE  | single cycle; the edge leaving it publishes rx byte, raises ss

module spi_xfer_ctrl (
   input  logic       PCLK,
   input  logic       PRESETn,
   input  logic [1:0] spi_mode,
   input  logic       spiswai,
   input  logic       send_data,
   input  logic [7:0] data_mosi,
   input  logic       lsbfe,
   input  logic       cpol,
   input  logic       cpha,
   input  logic       flag_low,
   input  logic       flag_high,
   input  logic       miso,
   output logic       ss,
   output logic       mosi,
   output logic       tip,
   output logic       receive_data,
   output logic [7:0] data_miso
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;

   logic [7:0] r_tx;
   logic [7:0] r_rx;
   logic [2:0] r_bit_cnt;
   logic       r_ss;
   logic       r_mosi;
   logic       r_tip;
   logic       r_rcv;
   logic [7:0] r_data_miso;

   logic       w_enable;
   logic       w_strobe;
   logic [2:0] w_idx;
   logic [2:0] w_cnt_nxt;
   logic [2:0] w_idx_nxt;

   assign w_enable  = (spi_mode == 2'b00) | ((spi_mode == 2'b01) & ~spiswai);
   assign w_strobe  = (cpol == cpha) ? flag_low : flag_high;
   assign w_idx     = lsbfe ? r_bit_cnt : (3'd7 - r_bit_cnt);
   assign w_cnt_nxt = r_bit_cnt + 3'd1;
   // Index of the bit to present on mosi after this strobe. It wraps
   // harmlessly on the final strobe because DONE ignores mosi.
   assign w_idx_nxt = lsbfe ? w_cnt_nxt : (3'd7 - w_cnt_nxt);

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (send_data && w_enable) w_state_nxt = ST_XFER;
         ST_XFER: begin
            // Losing enable takes priority over a coincident final strobe.
            if (!w_enable)                         w_state_nxt = ST_IDLE;
            else if (w_strobe && r_bit_cnt == 3'd7) w_state_nxt = ST_DONE;
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_tx        <= 8'h00;
         r_rx        <= 8'h00;
         r_bit_cnt   <= 3'd0;
         r_ss        <= 1'b1;
         r_mosi      <= 1'b0;
         r_tip       <= 1'b0;
         r_rcv       <= 1'b0;
         r_data_miso <= 8'h00;
      end else begin
         r_rcv <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_bit_cnt <= 3'd0;
               if (send_data && w_enable) begin
                  r_tx   <= data_mosi;
                  r_ss   <= 1'b0;
                  r_tip  <= 1'b1;
                  r_mosi <= lsbfe ? data_mosi[0] : data_mosi[7];
               end
            end
            ST_XFER: begin
               if (!w_enable) begin
                  r_ss      <= 1'b1;
                  r_tip     <= 1'b0;
                  r_bit_cnt <= 3'd0;
               end else if (w_strobe) begin
                  r_rx[w_idx] <= miso;
                  r_bit_cnt   <= w_cnt_nxt;
                  r_mosi      <= r_tx[w_idx_nxt];
               end
            end
            ST_DONE: begin
               r_data_miso <= r_rx;
               r_rcv       <= 1'b1;
               r_ss        <= 1'b1;
               r_tip       <= 1'b0;
               r_bit_cnt   <= 3'd0;
            end
            default: begin
               r_ss  <= 1'b1;
               r_tip <= 1'b0;
            end
         endcase
      end
   end

   assign ss           = r_ss;
   assign mosi         = r_mosi;
   assign tip          = r_tip;
   assign receive_data = r_rcv;
   assign data_miso    = r_data_miso;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
module tb_spi_xfer_ctrl;

   logic       PCLK      = 1'b0;
   logic       PRESETn   = 1'b1;
   logic [1:0] spi_mode  = 2'b00;
   logic       spiswai   = 1'b0;
   logic       send_data = 1'b0;
   logic [7:0] data_mosi = 8'h00;
   logic       lsbfe     = 1'b0;
   logic       cpol      = 1'b0;
   logic       cpha      = 1'b0;
   logic       flag_low  = 1'b0;
   logic       flag_high = 1'b0;
   logic       miso      = 1'b0;
   logic       ss;
   logic       mosi;
   logic       tip;
   logic       receive_data;
   logic [7:0] data_miso;

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q[$];

   spi_xfer_ctrl dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .spi_mode(spi_mode), .spiswai(spiswai),
      .send_data(send_data), .data_mosi(data_mosi), .lsbfe(lsbfe),
      .cpol(cpol), .cpha(cpha), .flag_low(flag_low), .flag_high(flag_high),
      .miso(miso), .ss(ss), .mosi(mosi), .tip(tip),
      .receive_data(receive_data), .data_miso(data_miso)
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every receive_data pulse must match a queued byte.
   always @(negedge PCLK) begin
      if (PRESETn && receive_data) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rcv: got pulse with data_miso %h expected no pulse", data_miso);
         end else begin
            chk("data_miso", data_miso, exp_q.pop_front());
            chk1("ss_at_rcv", ss, 1'b1);
            chk1("tip_at_rcv", tip, 1'b0);
         end
      end
   end

   task automatic clk1();
      @(posedge PCLK);
      #1;
   endtask

   task automatic start(input logic [7:0] d, input logic lsb);
      data_mosi = d;
      lsbfe     = lsb;
      send_data = 1'b1;
      clk1();
      send_data = 1'b0;
      chk1("ss_start", ss, 1'b0);
      chk1("tip_start", tip, 1'b1);
      chk1("mosi_first", mosi, lsb ? d[0] : d[7]);
   endtask

   // n strobes; between strobes the non-selected flag is pulsed and must be ignored.
   task automatic run_bits(input logic [7:0] d, input logic [7:0] m, input logic lsb,
                           input logic hi, input int n);
      for (int k = 0; k < n; k++) begin
         miso = lsb ? m[k] : m[7-k];
         if (hi) flag_high = 1'b1; else flag_low = 1'b1;
         clk1();
         flag_high = 1'b0;
         flag_low  = 1'b0;
         if (k < 7) begin
            chk1("mosi_bit", mosi, lsb ? d[k+1] : d[6-k]);
            if (hi) flag_low = 1'b1; else flag_high = 1'b1;
            clk1();
            flag_high = 1'b0;
            flag_low  = 1'b0;
            chk1("mosi_hold", mosi, lsb ? d[k+1] : d[6-k]);
            chk1("ss_low", ss, 1'b0);
         end
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 6 && exp_q.size() != 0; i++) clk1();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending responses expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      // reset values, asynchronously
      #2 PRESETn = 1'b0;
      #1;
      chk1("rst_ss", ss, 1'b1);
      chk1("rst_mosi", mosi, 1'b0);
      chk1("rst_tip", tip, 1'b0);
      chk1("rst_rcv", receive_data, 1'b0);
      chk("rst_data_miso", data_miso, 8'h00);
      repeat (3) clk1();
      @(negedge PCLK);
      PRESETn = 1'b1;
      clk1();

      // cpol=1 cpha=0: flag_high samples, LSB first
      cpol = 1'b1; cpha = 1'b0;
      exp_q.push_back(8'h96);
      start(8'h01, 1'b1);
      run_bits(8'h01, 8'h96, 1'b1, 1'b1, 8);
      chk1("ss_in_done", ss, 1'b0);
      drain();

      // run mode, MSB first, flag_low
      cpol = 1'b0; cpha = 1'b0;
      exp_q.push_back(8'h3C);
      start(8'hA5, 1'b0);
      run_bits(8'hA5, 8'h3C, 1'b0, 1'b0, 8);
      chk1("ss_in_done2", ss, 1'b0);
      drain();

      // abort via stop mode after 4 strobes
      start(8'h5A, 1'b0);
      run_bits(8'h5A, 8'h00, 1'b0, 1'b0, 4);
      spi_mode = 2'b10;
      clk1();
      chk1("abort_ss", ss, 1'b1);
      chk1("abort_tip", tip, 1'b0);
      spi_mode = 2'b00;
      repeat (4) clk1();
      chk("abort_data_miso", data_miso, 8'h3C);

      // wait mode with spiswai: requests ignored and not queued
      spi_mode = 2'b01; spiswai = 1'b1; data_mosi = 8'hC3; lsbfe = 1'b0; send_data = 1'b1;
      repeat (3) begin
         clk1();
         chk1("wait_ss", ss, 1'b1);
         chk1("wait_tip", tip, 1'b0);
      end
      send_data = 1'b0;
      spiswai   = 1'b0;
      clk1();
      chk1("not_queued_ss", ss, 1'b1);
      spiswai = 1'b1; send_data = 1'b1;
      clk1();
      chk1("wait_ss2", ss, 1'b1);
      spiswai = 1'b0;
      clk1();
      send_data = 1'b0;
      chk1("wait_go_ss", ss, 1'b0);
      chk1("wait_go_tip", tip, 1'b1);
      chk1("wait_go_mosi", mosi, 1'b1);
      exp_q.push_back(8'h5A);
      run_bits(8'hC3, 8'h5A, 1'b0, 1'b0, 8);
      drain();
      spi_mode = 2'b00;

      // reset mid-transfer, then fresh transfer on first qualifying edge
      start(8'h77, 1'b0);
      run_bits(8'h77, 8'h00, 1'b0, 1'b0, 5);
      #2 PRESETn = 1'b0;
      #1;
      chk1("mrst_ss", ss, 1'b1);
      chk1("mrst_tip", tip, 1'b0);
      chk1("mrst_mosi", mosi, 1'b0);
      chk1("mrst_rcv", receive_data, 1'b0);
      chk("mrst_data_miso", data_miso, 8'h00);
      @(negedge PCLK);
      PRESETn = 1'b1;
      exp_q.push_back(8'hFF);
      start(8'hFF, 1'b0);
      run_bits(8'hFF, 8'hFF, 1'b0, 1'b0, 8);
      drain();

      // abort coincident with the 8th strobe: abort wins
      start(8'h81, 1'b0);
      run_bits(8'h81, 8'h00, 1'b0, 1'b0, 7);
      miso = 1'b0; flag_low = 1'b1; spi_mode = 2'b10;
      clk1();
      flag_low = 1'b0; spi_mode = 2'b00;
      chk1("abort8_ss", ss, 1'b1);
      chk1("abort8_tip", tip, 1'b0);
      repeat (3) clk1();
      chk("abort8_data_miso", data_miso, 8'hFF);

      // back-to-back with send_data held; data_mosi changed mid-transfer
      exp_q.push_back(8'h3C);
      exp_q.push_back(8'hA5);
      data_mosi = 8'hE7; lsbfe = 1'b0; send_data = 1'b1;
      clk1();
      chk1("b2b_ss", ss, 1'b0);
      chk1("b2b_mosi", mosi, 1'b1);
      data_mosi = 8'h0F;
      run_bits(8'hE7, 8'h3C, 1'b0, 1'b0, 8);
      chk1("b2b_done_ss", ss, 1'b0);
      chk1("b2b_done_tip", tip, 1'b1);
      clk1();
      chk1("b2b_rcv", receive_data, 1'b1);
      chk1("b2b_rcv_ss", ss, 1'b1);
      clk1();
      send_data = 1'b0;
      chk1("b2b_restart_ss", ss, 1'b0);
      chk1("b2b_restart_tip", tip, 1'b1);
      chk1("b2b_restart_mosi", mosi, 1'b0);
      run_bits(8'h0F, 8'hA5, 1'b0, 1'b0, 8);
      drain();

      repeat (2) clk1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
